// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - EX/MEM forwarding select and load-use stall controller (option macro: FWD_R0_ZERO_EN)
module fwd_ctrl #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_we,
  input  logic             id_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_EX  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // The register file is write-first, so a producer in WB never needs a
  // forward and is never a hazard; only the EX and MEM tags are stored.
  // Only the EX slot needs the load flag: a load in MEM is already forwardable.
  logic            ex_v, ex_we, ex_ld;
  logic [RA_W-1:0] ex_rd;
  logic            mem_v, mem_we;
  logic [RA_W-1:0] mem_rd;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic ex_wr_ok, mem_wr_ok;
  logic take_id;
  logic [1:0] sel_a_nxt, sel_b_nxt;

  // Decide whether each slot holds a trackable write (r0 optionally hardwired).
  always_comb begin
    ex_wr_ok  = ex_v & ex_we;
    mem_wr_ok = mem_v & mem_we;
`ifdef FWD_R0_ZERO_EN
    if (ex_rd == '0)  ex_wr_ok  = 1'b0;
    if (mem_rd == '0) mem_wr_ok = 1'b0;
`else
`endif
  end

  // Source-tag matches, hazard detection and next operand selects.
  always_comb begin
    ex_hit_a  = ex_wr_ok & (ex_rd == id_rs1);
    ex_hit_b  = ex_wr_ok & (ex_rd == id_rs2);
    mem_hit_a = mem_wr_ok & (mem_rd == id_rs1);
    mem_hit_b = mem_wr_ok & (mem_rd == id_rs2);
    stall     = id_valid & ~flush & ex_ld & (ex_hit_a | ex_hit_b);
    take_id   = id_valid & ~flush & ~stall;
    sel_a_nxt = SEL_EX;
    sel_b_nxt = SEL_EX;
    if (take_id) begin
      // Youngest producer wins: EX match beats MEM match.
      if (ex_hit_a)       sel_a_nxt = SEL_MEM;
      else if (mem_hit_a) sel_a_nxt = SEL_WB;
      if (ex_hit_b)       sel_b_nxt = SEL_MEM;
      else if (mem_hit_b) sel_b_nxt = SEL_WB;
    end
  end

  // Advance the tag pipeline; a stalled, flushed or empty decode enters as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v   <= 1'b0;
      ex_we  <= 1'b0;
      ex_ld  <= 1'b0;
      ex_rd  <= '0;
      mem_v  <= 1'b0;
      mem_we <= 1'b0;
      mem_rd <= '0;
    end else begin
      mem_v  <= ex_v;
      mem_we <= ex_we;
      mem_rd <= ex_rd;
      ex_v   <= take_id;
      ex_we  <= take_id & id_we;
      ex_ld  <= take_id & id_load;
      ex_rd  <= take_id ? id_rd : '0;
    end
  end

  // Register the operand selects for use during the EX cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_a <= SEL_EX;
      sel_b <= SEL_EX;
    end else begin
      sel_a <= sel_a_nxt;
      sel_b <= sel_b_nxt;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb/tb_fwd_ctrl.sv - scoreboard bench for fwd_ctrl
module tb_fwd_ctrl;
  localparam int RA_W  = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_we, id_load, flush;
  logic [RA_W-1:0]  id_rs1, id_rs2, id_rd;
  logic             stall;
  logic [1:0]       sel_a, sel_b;
  logic [CNT_W-1:0] stall_cnt;

  fwd_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load), .flush(flush),
    .stall(stall), .sel_a(sel_a), .sel_b(sel_b), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model of the tag slots and counter.
  bit              m_ex_v, m_ex_we, m_ex_ld, m_mem_v, m_mem_we;
  logic [RA_W-1:0] m_ex_rd, m_mem_rd;
  int              m_cnt;

  typedef struct { logic [1:0] a; logic [1:0] b; } sel_t;
  sel_t sb[$];
  bit   last_st;

  function automatic bit writes(bit v, bit we, logic [RA_W-1:0] rd, logic [RA_W-1:0] rs);
`ifdef FWD_R0_ZERO_EN
    return v && we && rd == rs && rd != 0;
`else
    return v && we && rd == rs;
`endif
  endfunction

  function automatic logic [1:0] exp_sel(logic [RA_W-1:0] rs);
    if (writes(m_ex_v, m_ex_we, m_ex_rd, rs)) return 2'd1;
    if (writes(m_mem_v, m_mem_we, m_mem_rd, rs)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    m_ex_v = 0; m_ex_we = 0; m_ex_ld = 0; m_ex_rd = '0;
    m_mem_v = 0; m_mem_we = 0; m_mem_rd = '0;
    m_cnt = 0;
    sb.delete();
  endtask

  task automatic step(input bit v, input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                      input logic [RA_W-1:0] rd, input bit we, input bit ld, input bit fl);
    bit   st;
    sel_t e;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_we = we; id_load = ld; flush = fl;
    #1;
    st = v && !fl && m_ex_v && m_ex_ld &&
         (writes(m_ex_v, m_ex_we, m_ex_rd, rs1) || writes(m_ex_v, m_ex_we, m_ex_rd, rs2));
    check("stall", stall, st);
    last_st = st;
    if (v && !fl && !st) begin
      e.a = exp_sel(rs1);
      e.b = exp_sel(rs2);
    end else begin
      e.a = 2'd0;
      e.b = 2'd0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    m_mem_v = m_ex_v; m_mem_we = m_ex_we; m_mem_rd = m_ex_rd;
    m_ex_v = v && !fl && !st;
    m_ex_we = m_ex_v && we;
    m_ex_ld = m_ex_v && ld;
    m_ex_rd = m_ex_v ? rd : '0;
    if (st && m_cnt < CNT_MAX) m_cnt++;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("sel_a", sel_a, e.a);
      check("sel_b", sel_b, e.b);
    end
    check("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  int cnt0;

  initial begin
    rst = 1'b1;
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_we = 0; id_load = 0; flush = 0;
    model_clear();
    #1;
    check("rst_sel_a", sel_a, 0);
    check("rst_sel_b", sel_b, 0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // EX -> EX forward
    bubbles(2);
    step(1, 1, 2, 3, 1, 0, 0);
    step(1, 3, 5, 9, 0, 0, 0);
    check("exex_a", sel_a, 1);
    check("exex_b", sel_b, 0);

    // MEM forward
    bubbles(2);
    step(1, 1, 2, 4, 1, 0, 0);
    step(1, 1, 2, 6, 1, 0, 0);
    step(1, 1, 4, 8, 0, 0, 0);
    check("mem_b", sel_b, 2);

    // EX beats MEM on the same source
    bubbles(2);
    step(1, 1, 2, 4, 1, 0, 0);
    step(1, 1, 2, 4, 1, 0, 0);
    step(1, 1, 4, 8, 0, 0, 0);
    check("prio_b", sel_b, 1);

    // rs1 == rs2
    step(1, 8, 8, 9, 0, 0, 0);
    check("same_ab", {30'd0, sel_a}, {30'd0, sel_b});

    // Load-use: one stall, then select 2
    bubbles(2);
    cnt0 = m_cnt;
    step(1, 1, 2, 7, 1, 1, 0);
    step(1, 7, 1, 10, 1, 0, 0);
    check("lu_stalled", last_st, 1);
    check("lu_sel_a0", sel_a, 0);
    check("lu_cnt", stall_cnt, cnt0 + 1);
    step(1, 7, 1, 10, 1, 0, 0);
    check("lu_restall", last_st, 0);
    check("lu_sel_a2", sel_a, 2);

    // Flush beats the hazard
    bubbles(2);
    cnt0 = m_cnt;
    step(1, 1, 2, 7, 1, 1, 0);
    step(1, 7, 1, 10, 1, 0, 1);
    check("fl_stall", last_st, 0);
    check("fl_sel_a", sel_a, 0);
    check("fl_cnt", stall_cnt, cnt0);

    // r0 producer
    bubbles(2);
    step(1, 1, 2, 0, 1, 0, 0);
    step(1, 0, 5, 2, 0, 0, 0);
`ifdef FWD_R0_ZERO_EN
    check("r0_sel_a", sel_a, 0);
`else
    check("r0_sel_a", sel_a, 1);
`endif

    // Random traffic over a small register set to provoke hazards
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0);

    // Saturation after 20 forced stalls
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 2, 7, 1, 1, 0);
      step(1, 7, 1, 10, 0, 0, 0);
    end
    check("sat_cnt", stall_cnt, 15);

    // Asynchronous reset in the middle of a stall
    bubbles(1);
    step(1, 1, 2, 7, 1, 1, 0);
    @(negedge clk);
    id_valid = 1; id_rs1 = 7; id_rs2 = 1; id_rd = 10; id_we = 1; id_load = 0; flush = 0;
    #1;
    check("pre_rst_stall", stall, 1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_sel_a", sel_a, 0);
    check("mid_rst_sel_b", sel_b, 0);
    check("mid_rst_cnt", stall_cnt, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step(1, 7, 1, 10, 1, 0, 0);
    check("post_rst_stall", last_st, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
